// File: rtl/reg_output_collector_pkg.sv
// Shared definitions for the upsampler tile registers: pixel width, tile geometry,
// FSM encoding and the block-index field layout used by both input and output sides.
package reg_output_collector_pkg;

    localparam int LENGTH  = 12;
    localparam int OUT_DIM = 8;
    localparam int BLOCKS  = 16;
    localparam int ROW_W   = 3;

    // Block index layout: block row in [3:2], block column in [1:0].
    localparam int BLK_ROW_MSB = 3;
    localparam int BLK_ROW_LSB = 2;
    localparam int BLK_COL_MSB = 1;
    localparam int BLK_COL_LSB = 0;

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_DRAIN = 2'b01
    } state_e;

    function automatic logic [ROW_W-1:0] blk_top_row(input logic [3:0] addr);
        return {addr[BLK_ROW_MSB:BLK_ROW_LSB], 1'b0};
    endfunction

    function automatic logic [ROW_W-1:0] blk_left_col(input logic [3:0] addr);
        return {addr[BLK_COL_MSB:BLK_COL_LSB], 1'b0};
    endfunction

endpackage

// File: rtl/reg_output_collector_upsample_row_mux.sv
// Selects one 8-pixel row of the output tile buffer for the row beat; forced to zero
// when disabled so the bus is quiet while the collector is held in reset.
module upsample_row_mux
    import reg_output_collector_pkg::*;
#(
    parameter int length = LENGTH
) (
    input  logic [OUT_DIM-1:0][OUT_DIM-1:0][length-1:0] rows_i,
    input  logic [ROW_W-1:0]                            sel_i,
    input  logic                                        en_i,
    output logic [OUT_DIM*length-1:0]                   dout_o
);

    always_comb begin
        dout_o = '0;
        if (en_i) begin
            dout_o = rows_i[sel_i];
        end
    end

endmodule

// File: rtl/reg_output_collector.sv
// Collects sixteen 2x2 interpolated blocks into an 8x8 tile, then streams it out one
// row per valid/ready beat. Single buffer: FILL and DRAIN never overlap.
module reg_output_collector
    import reg_output_collector_pkg::*;
#(
    parameter int length = LENGTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [3:0]                  addr_block,
    input  logic [length-1:0]           din1,
    input  logic [length-1:0]           din2,
    input  logic [length-1:0]           din3,
    input  logic [length-1:0]           din4,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [length*OUT_DIM-1:0]   dout,
    output logic [ROW_W-1:0]            out_row,
    output logic                        out_last
);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds its payload stable until that edge, ready may change freely.

    state_e                                      state_q;
    logic [BLOCKS-1:0]                           mask_q;
    logic [BLOCKS-1:0]                           mask_d;
    logic [ROW_W-1:0]                            row_q;
    logic [OUT_DIM-1:0][OUT_DIM-1:0][length-1:0] buf_q;
    logic [ROW_W-1:0]                            wr_row;
    logic [ROW_W-1:0]                            wr_col;

    assign wr_row = blk_top_row(addr_block);
    assign wr_col = blk_left_col(addr_block);
    assign mask_d = mask_q | ({{(BLOCKS-1){1'b0}}, 1'b1} << addr_block);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            mask_q  <= '0;
            row_q   <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (in_valid) begin
                        buf_q[wr_row][wr_col]                 <= din1;
                        buf_q[wr_row][wr_col | 3'd1]          <= din2;
                        buf_q[wr_row | 3'd1][wr_col]          <= din3;
                        buf_q[wr_row | 3'd1][wr_col | 3'd1]   <= din4;
                        mask_q <= mask_d;
                        if (&mask_d) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        row_q <= row_q + 3'd1;
                        if (row_q == ROW_W'(OUT_DIM - 1)) begin
                            state_q <= ST_FILL;
                            mask_q  <= '0;
                        end
                    end
                end
                default: begin
                    // Unused encodings fall back to an empty FILL.
                    state_q <= ST_FILL;
                    mask_q  <= '0;
                    row_q   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_FILL) && !rst;
    assign out_valid = (state_q == ST_DRAIN) && !rst;
    assign out_row   = rst ? '0 : row_q;
    assign out_last  = out_valid && (row_q == ROW_W'(OUT_DIM - 1));

    upsample_row_mux #(
        .length(length)
    ) u_row_mux (
        .rows_i (buf_q),
        .sel_i  (row_q),
        .en_i   (!rst),
        .dout_o (dout)
    );

endmodule

// File: tb/tb_reg_output_collector.sv
// Bench for reg_output_collector: block driver feeding a tile model, expected row beats
// queued on tile completion and popped by an independent output monitor.
module tb_reg_output_collector;

    localparam int L  = 12;
    localparam int DW = 8 * L;
    localparam int W  = 1 + 3 + DW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    addr_block;
    logic [L-1:0]  din1, din2, din3, din4;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dout;
    logic [2:0]    out_row;
    logic          out_last;

    reg_output_collector #(.length(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr_block (addr_block),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .din4       (din4),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .out_row    (out_row),
        .out_last   (out_last)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [L-1:0] tile[8][8];
    logic [15:0]  model_mask;
    int n_pass  = 0;
    int n_total = 0;
    int beats   = 0;
    int t7      = -100;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    function automatic logic [L-1:0] pix(input int sel, input int y, input int x);
        case (sel)
            0:       return L'(16 * y + x);
            1:       return L'(12'hFFF - (16 * y + x));
            default: return L'((y * 37 + x * 11 + 5) & 12'hFFF);
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        model_mask = '0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                tile[y][x] = '0;
    endtask

    task automatic model_write(input logic [3:0] a, input logic [L-1:0] p1, p2, p3, p4);
        int y, x;
        logic [DW-1:0] row;
        y = 2 * int'(a[3:2]);
        x = 2 * int'(a[1:0]);
        tile[y][x] = p1;
        tile[y][x+1] = p2;
        tile[y+1][x] = p3;
        tile[y+1][x+1] = p4;
        model_mask = model_mask | (16'd1 << a);
        if (model_mask == 16'hFFFF) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) row[c*L +: L] = tile[r][c];
                exp_q.push_back({(r == 7), 3'(r), row});
            end
            model_mask = '0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_block(input logic [3:0] a, input logic [L-1:0] p1, p2, p3, p4,
                               output int acc_cyc);
        bit done;
        done = 0;
        acc_cyc = -1;
        in_valid = 1'b1;
        addr_block = a;
        din1 = p1; din2 = p2; din3 = p3; din4 = p4;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                acc_cyc = cyc;
                check("no_early_drain", out_valid, 1'b0);
                model_write(a, p1, p2, p3, p4);
            end
            @(posedge clk); #1;
        end
        if (!done) check("accept_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic write_tile(input int sel, input bit rev, input bit gaps,
                              input int ovr_blk, input logic [L-1:0] ovr_val, input int skip);
        int a, y, x, acc;
        logic [L-1:0] p1, p2, p3, p4;
        for (int i = 0; i < 16; i++) begin
            a = rev ? 15 - i : i;
            if (a != skip) begin
                if (gaps) repeat (i % 3) begin @(posedge clk); #1; end
                y = 2 * (a / 4);
                x = 2 * (a % 4);
                p1 = pix(sel, y, x);     p2 = pix(sel, y, x + 1);
                p3 = pix(sel, y + 1, x); p4 = pix(sel, y + 1, x + 1);
                if (a == ovr_blk) begin p1 = ovr_val; p2 = ovr_val; p3 = ovr_val; p4 = ovr_val; end
                write_block(4'(a), p1, p2, p3, p4, acc);
            end
        end
        check("first_valid_latency", out_valid, 1'b1);
    endtask

    task automatic drain(input logic [3:0] pat);
        int start;
        start = beats;
        for (int k = 0; k < 200 && beats < start + 8; k++) begin
            out_ready = pat[k % 4];
            @(negedge clk);
            check("in_ready_low_in_drain", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_beats", 128'(beats - start), 128'd8);
    endtask

    // ---------------- output monitor ----------------
    initial begin : monitor
        logic [W-1:0]  e;
        logic          stalled;
        logic [DW-1:0] hold_dout;
        logic [2:0]    hold_row;
        stalled = 1'b0;
        hold_dout = '0;
        hold_row = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && out_valid) begin
                    check("stall_dout", dout, hold_dout);
                    check("stall_row", out_row, hold_row);
                end
                stalled   = out_valid && !out_ready;
                hold_dout = dout;
                hold_row  = out_row;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_dout", dout, e[DW-1:0]);
                        check("beat_row", out_row, e[DW+2:DW]);
                        check("beat_last", out_last, e[W-1]);
                    end
                    beats++;
                    if (out_last) t7 = cyc;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_total++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; addr_block = '0;
        din1 = '0; din2 = '0; din3 = '0; din4 = '0;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1'b0);
        check("out_valid_in_reset", out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_dout", dout, '0);
        check("rst_out_row", out_row, 3'd0);
        check("rst_out_last", out_last, 1'b0);
        @(posedge clk); #1;

        // 1: in-order fill, full-rate drain
        write_tile(0, 0, 0, -1, '0, -1);
        drain(4'b1111);

        // 2: reverse order with idle gaps
        write_tile(0, 1, 1, -1, '0, -1);
        drain(4'b1111);

        // 3: block 5 written twice, second value wins
        write_block(4'd5, 12'h111, 12'h111, 12'h111, 12'h111, acc);
        write_tile(0, 0, 0, 5, 12'hABC, -1);
        drain(4'b1111);

        // 4: stalled drain with in_valid asserted
        write_tile(1, 0, 0, -1, '0, -1);
        in_valid = 1'b1; addr_block = 4'd3;
        din1 = 12'h555; din2 = 12'h555; din3 = 12'h555; din4 = 12'h555;
        drain(4'b1001);

        // 5: reset after three rows
        write_tile(2, 0, 0, -1, '0, -1);
        repeat (3) begin out_ready = 1'b1; @(posedge clk); #1; end
        rst = 1'b1; out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 1'b0);
        check("post_rst_dout", dout, '0);
        check("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        write_tile(1, 1, 0, -1, '0, -1);
        drain(4'b1111);

        // 6: back-to-back tiles, in_valid held across the last row handshake
        write_tile(0, 0, 0, -1, '0, -1);
        in_valid = 1'b1; addr_block = 4'd0;
        din1 = pix(2, 0, 0); din2 = pix(2, 0, 1); din3 = pix(2, 1, 0); din4 = pix(2, 1, 1);
        begin
            int start;
            start = beats;
            for (int k = 0; k < 200 && beats < start + 8; k++) begin
                out_ready = 1'b1;
                @(negedge clk);
                check("in_ready_low_in_drain", in_ready, 1'b0);
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
            check("b2b_beats", 128'(beats - start), 128'd8);
        end
        write_block(4'd0, pix(2, 0, 0), pix(2, 0, 1), pix(2, 1, 0), pix(2, 1, 1), acc);
        check("b2b_accept_cycle", 128'(acc), 128'(t7 + 1));
        write_tile(2, 0, 0, -1, '0, 0);
        drain(4'b1111);

        repeat (4) begin @(posedge clk); #1; end
        check("exp_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
